// File: rtl/tdm_demux4.sv
// tdm_demux4 - time-division 1-to-4 demultiplexer (receive side of the
// 4:1 TDM channel multiplexer).
//
// A serial stream of WIDTH-bit beats is grouped into 4-slot frames. Slot 0 is
// marked by frame_sync. Each complete frame is published atomically on
// ch_a..ch_d (slot 0..3), together with a one-cycle frame_valid pulse.
//
// Optional build macro: TDM_DEMUX_PARITY_EN
//   When it is defined, the block has an even-parity input din_par and a
//   per-slot parity error output par_err[3:0]. Both are published with the
//   frame. When it is undefined, those ports and the parity logic are absent.
//
// Ports:
//   clk          system clock; all state changes on the rising edge
//   rst          synchronous, active-high reset
//   din          serial beat data (WIDTH bits)
//   din_valid    a beat is present this cycle
//   frame_sync   marks din as slot 0; ignored when din_valid=0
//   din_par      (parity build only) even parity bit for din
//   ch_a..ch_d   slot 0..3 data of the last complete frame
//   frame_valid  one-cycle pulse; ch_a..ch_d were just updated
//   slot         slot index that the next accepted beat will occupy
//   locked       high while frame alignment is held
//   sync_err     one-cycle pulse on a framing violation
//   par_err      (parity build only) bit k set if slot k of the frame failed parity

module tdm_demux4 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             frame_sync,
`ifdef TDM_DEMUX_PARITY_EN
  input  logic             din_par,
  output logic [3:0]       par_err,
`endif
  output logic [WIDTH-1:0] ch_a,
  output logic [WIDTH-1:0] ch_b,
  output logic [WIDTH-1:0] ch_c,
  output logic [WIDTH-1:0] ch_d,
  output logic             frame_valid,
  output logic [1:0]       slot,
  output logic             locked,
  output logic             sync_err
);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t state;

  // Slots 0..2 of the frame being assembled. Slot 3 is never staged: it goes
  // directly from din to ch_d on the edge that completes the frame.
  logic [WIDTH-1:0] s0, s1, s2;

`ifdef TDM_DEMUX_PARITY_EN
  // Per-slot parity failures are staged with the data, so they are published
  // (or discarded) together with their frame.
  logic [2:0] perr_stage;
  logic       beat_bad;

  // Even parity: din together with din_par must XOR to zero.
  assign beat_bad = ^{din, din_par};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HUNT;
      slot        <= 2'd0;
      s0          <= '0;
      s1          <= '0;
      s2          <= '0;
      ch_a        <= '0;
      ch_b        <= '0;
      ch_c        <= '0;
      ch_d        <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      locked      <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      perr_stage  <= '0;
      par_err     <= '0;
`endif
    end else begin
      // Both status outputs are pulses. They clear unless set again below.
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;

      if (din_valid) begin
        unique case (state)
          HUNT: begin
            // While hunting, non-sync beats are dropped silently.
            if (frame_sync) begin
              s0     <= din;
              slot   <= 2'd1;
              state  <= LOCKED;
              locked <= 1'b1;
`ifdef TDM_DEMUX_PARITY_EN
              perr_stage <= {2'b00, beat_bad};
`endif
            end
          end

          LOCKED: begin
            if (frame_sync) begin
              // A sync beat always starts a new frame. If it arrives at slot
              // 1..3, it is an early sync: the partial frame is discarded.
              // The stale s1/s2 contents are overwritten before they can be
              // published, so they do not need to be cleared.
              if (slot != 2'd0) sync_err <= 1'b1;
              s0   <= din;
              slot <= 2'd1;
`ifdef TDM_DEMUX_PARITY_EN
              perr_stage <= {2'b00, beat_bad};
`endif
            end else begin
              unique case (slot)
                2'd0: begin
                  // A slot 0 beat without sync means alignment was lost.
                  sync_err <= 1'b1;
                  state    <= HUNT;
                  locked   <= 1'b0;
                  slot     <= 2'd0;
                end
                2'd1: begin
                  s1   <= din;
                  slot <= 2'd2;
`ifdef TDM_DEMUX_PARITY_EN
                  perr_stage[1] <= beat_bad;
`endif
                end
                2'd2: begin
                  s2   <= din;
                  slot <= 2'd3;
`ifdef TDM_DEMUX_PARITY_EN
                  perr_stage[2] <= beat_bad;
`endif
                end
                2'd3: begin
                  // The frame is complete. All four channels update on the
                  // same edge.
                  ch_a        <= s0;
                  ch_b        <= s1;
                  ch_c        <= s2;
                  ch_d        <= din;
                  frame_valid <= 1'b1;
                  slot        <= 2'd0;
`ifdef TDM_DEMUX_PARITY_EN
                  par_err     <= {beat_bad, perr_stage};
`endif
                end
                default: ;
              endcase
            end
          end

          default: begin
            state  <= HUNT;
            locked <= 1'b0;
            slot   <= 2'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux4.sv
// Self-checking bench for tdm_demux4. A frame-level reference model holds the
// partial frame as a queue of beats. The slot index is the queue length. On
// every cycle, every output is compared against the model.

module tb_tdm_demux4;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             frame_sync;
  logic             din_par;
  logic [WIDTH-1:0] ch_a, ch_b, ch_c, ch_d;
  logic             frame_valid;
  logic [1:0]       slot;
  logic             locked;
  logic             sync_err;
`ifdef TDM_DEMUX_PARITY_EN
  logic [3:0]       par_err;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tdm_demux4 #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_valid   (din_valid),
    .frame_sync  (frame_sync),
`ifdef TDM_DEMUX_PARITY_EN
    .din_par     (din_par),
    .par_err     (par_err),
`endif
    .ch_a        (ch_a),
    .ch_b        (ch_b),
    .ch_c        (ch_c),
    .ch_d        (ch_d),
    .frame_valid (frame_valid),
    .slot        (slot),
    .locked      (locked),
    .sync_err    (sync_err)
  );

  // Reference model state
  bit               m_locked;
  logic [WIDTH-1:0] m_q[$];     // beats of the partial frame
  bit               m_bad_q[$]; // parity failure flags for those beats
  logic [WIDTH-1:0] m_ch[4];
  logic [3:0]       m_par;
  bit               m_fv, m_se;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_step(input bit r, input bit v, input bit s,
                                     input logic [WIDTH-1:0] d, input bit p);
    bit bad;
    bad = ^{d, p};
    m_fv = 0;
    m_se = 0;
    if (r) begin
      m_locked = 0;
      m_q.delete();
      m_bad_q.delete();
      for (int i = 0; i < 4; i++) m_ch[i] = '0;
      m_par = '0;
    end else if (v) begin
      if (s) begin
        if (m_locked && m_q.size() != 0) m_se = 1;
        m_locked = 1;
        m_q.delete();
        m_bad_q.delete();
        m_q.push_back(d);
        m_bad_q.push_back(bad);
      end else if (m_locked) begin
        if (m_q.size() == 0) begin
          m_se = 1;
          m_locked = 0;
        end else begin
          m_q.push_back(d);
          m_bad_q.push_back(bad);
          if (m_q.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
              m_ch[i]  = m_q[i];
              m_par[i] = m_bad_q[i];
            end
            m_fv = 1;
            m_q.delete();
            m_bad_q.delete();
          end
        end
      end
    end
  endfunction

  // Drive one cycle, let the edge happen, update the model, then check.
  task automatic cyc(input bit r, input bit v, input bit s,
                     input logic [WIDTH-1:0] d, input bit p);
    rst = r;
    din_valid = v;
    frame_sync = s;
    din = d;
    din_par = p;
    @(posedge clk);
    model_step(r, v, s, d, p);
    #1;
    chk("ch_a", 32'(ch_a), 32'(m_ch[0]));
    chk("ch_b", 32'(ch_b), 32'(m_ch[1]));
    chk("ch_c", 32'(ch_c), 32'(m_ch[2]));
    chk("ch_d", 32'(ch_d), 32'(m_ch[3]));
    chk("frame_valid", 32'(frame_valid), 32'(m_fv));
    chk("sync_err", 32'(sync_err), 32'(m_se));
    chk("locked", 32'(locked), 32'(m_locked));
    chk("slot", 32'(slot), 32'(m_q.size()));
`ifdef TDM_DEMUX_PARITY_EN
    chk("par_err", 32'(par_err), 32'(m_par));
`endif
  endtask

  // Good-parity beat
  task automatic beat(input bit s, input logic [WIDTH-1:0] d);
    cyc(0, 1, s, d, ^d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 8'h00, 0);
  endtask

  initial begin
    rst = 1; din = '0; din_valid = 0; frame_sync = 0; din_par = 0;
    m_locked = 0;
    m_par = '0;
    m_fv = 0;
    m_se = 0;
    for (int i = 0; i < 4; i++) m_ch[i] = '0;

    // Reset, then a single frame
    cyc(1, 0, 0, 8'h00, 0);
    cyc(1, 1, 1, 8'hEE, 0);   // reset overrides a concurrent beat
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_slot", 32'(slot), 32'd0);
    beat(1, 8'h11);
    chk("t1_locked", 32'(locked), 32'd1);
    beat(0, 8'h22);
    beat(0, 8'h33);
    chk("t1_no_partial", 32'(ch_a), 32'd0);
    beat(0, 8'h44);
    chk("t1_fv", 32'(frame_valid), 32'd1);
    chk("t1_ch", {ch_a, ch_b, ch_c, ch_d}, 32'h11223344);
    idle(1);
    chk("t1_fv_pulse", 32'(frame_valid), 32'd0);

    // Gapped beats
    beat(1, 8'h11); idle(3);
    chk("t2_slot_hold", 32'(slot), 32'd1);
    beat(0, 8'h22); idle(3);
    beat(0, 8'h33); idle(3);
    beat(0, 8'h44);
    chk("t2_fv", 32'(frame_valid), 32'd1);
    idle(2);

    // Early sync
    beat(1, 8'hA1);
    beat(0, 8'hA2);
    beat(1, 8'hB1);
    chk("t3_sync_err", 32'(sync_err), 32'd1);
    chk("t3_locked", 32'(locked), 32'd1);
    beat(0, 8'hB2);
    beat(0, 8'hB3);
    beat(0, 8'hB4);
    chk("t3_ch", {ch_a, ch_b, ch_c, ch_d}, 32'hB1B2B3B4);

    // Missing sync at slot 0
    beat(0, 8'h55);
    chk("t4_sync_err", 32'(sync_err), 32'd1);
    chk("t4_locked", 32'(locked), 32'd0);
    chk("t4_hold", {ch_a, ch_b, ch_c, ch_d}, 32'hB1B2B3B4);
    beat(0, 8'h66);
    beat(0, 8'h77);
    chk("t4_ignored_err", 32'(sync_err), 32'd0);
    beat(1, 8'h01); beat(0, 8'h02); beat(0, 8'h03); beat(0, 8'h04);
    chk("t4_relock", {ch_a, ch_b, ch_c, ch_d}, 32'h01020304);

    // Reset in the middle of a frame
    beat(1, 8'h01);
    beat(0, 8'h02);
    cyc(1, 1, 0, 8'h03, 0);
    chk("t5_ch_clear", {ch_a, ch_b, ch_c, ch_d}, 32'h0);
    chk("t5_slot", 32'(slot), 32'd0);
    beat(1, 8'h0A); beat(0, 8'h0B); beat(0, 8'h0C); beat(0, 8'h0D);
    chk("t5_ch", {ch_a, ch_b, ch_c, ch_d}, 32'h0A0B0C0D);

`ifdef TDM_DEMUX_PARITY_EN
    // Bad parity on slot 2, then a clean frame
    beat(1, 8'h21); beat(0, 8'h22); cyc(0, 1, 0, 8'h23, ~^8'h23); beat(0, 8'h24);
    chk("t6_par_bad", 32'(par_err), 32'h4);
    beat(1, 8'h31); beat(0, 8'h32); beat(0, 8'h33); beat(0, 8'h34);
    chk("t6_par_clean", 32'(par_err), 32'h0);
`endif

    // Randomized traffic, biased toward well-formed frames
    for (int i = 0; i < 4000; i++) begin
      bit r, v, s, p;
      logic [WIDTH-1:0] d;
      r = ($urandom_range(0, 149) == 0);
      v = ($urandom_range(0, 3) != 0);
      if (m_q.size() == 0) s = ($urandom_range(0, 7) != 0);
      else                 s = ($urandom_range(0, 11) == 0);
      d = WIDTH'($urandom);
      p = ($urandom_range(0, 9) == 0) ? ~^d : ^d;
      cyc(r, v, s, d, p);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
